phy_rx_sp_nlane: RTL and testbench

PHY_RX_SP_NLANE -- requirements
Module: phy_rx_sp_nlane

---
 rtl/phy_rx_sp_nlane_if.sv | 20 ++
 rtl/phy_rx_sp_nlane.sv | 121 ++++++++++++
 tb/tb_phy_rx_sp_nlane.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/phy_rx_sp_nlane_if.sv
// Lane-bundle interface: serial bits and enable in, per-lane bytes/valid/lock out.
// err_cnt exists only when PHY_RX_ERRCNT_EN is defined.
interface phy_rx_sp_nlane_if #(
    parameter int LANES = 2
);
    logic                 enable;
    logic [LANES-1:0]     in;
    logic [8*LANES-1:0]   data_out;
    logic [LANES-1:0]     valid_out;
    logic [LANES-1:0]     active;
`ifdef PHY_RX_ERRCNT_EN
    logic [8*LANES-1:0]   err_cnt;

    modport master (output enable, in, input data_out, valid_out, active, err_cnt);
    modport slave  (input enable, in, output data_out, valid_out, active, err_cnt);
`else
    modport master (output enable, in, input data_out, valid_out, active);
    modport slave  (input enable, in, output data_out, valid_out, active);
`endif
endinterface

// File: rtl/phy_rx_sp_nlane.sv
// N-lane serial-to-parallel receiver with comma lock; bytes registered 1 edge after last bit, no backpressure.
// Optional per-lane SEARCH-state error counter enabled by macro PHY_RX_ERRCNT_EN.
module phy_rx_sp_nlane #(
    parameter int         LANES       = 2,
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         COMMA_COUNT = 4
) (
    input  logic                clk_8f,
    input  logic                reset_L,
    phy_rx_sp_nlane_if.slave    rx
);
    localparam logic [3:0] LOCK_CNT = 4'(COMMA_COUNT);

    typedef enum logic {SEARCH = 1'b0, ACTIVE = 1'b1} state_e;

    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q     [LANES];
    logic [6:0]       shift_d     [LANES];
    state_e           state_q     [LANES];
    state_e           state_d     [LANES];
    logic [3:0]       comma_cnt_q [LANES];
    logic [3:0]       comma_cnt_d [LANES];
    logic [7:0]       data_q      [LANES];
    logic [7:0]       data_d      [LANES];
    logic [7:0]       byte_w      [LANES];
    logic [LANES-1:0] valid_q, valid_d;
    logic             boundary;
`ifdef PHY_RX_ERRCNT_EN
    logic [7:0]       err_q       [LANES];
    logic [7:0]       err_d       [LANES];
`endif

    // Byte framing comes only from this counter; there is no bit-slip.
    assign boundary  = rx.enable && (bit_cnt_q == 3'd7);
    assign bit_cnt_d = rx.enable ? bit_cnt_q + 3'd1 : 3'd0;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < LANES; i++) begin
            byte_w[i]      = {shift_q[i], rx.in[i]};
            shift_d[i]     = shift_q[i];
            state_d[i]     = state_q[i];
            comma_cnt_d[i] = comma_cnt_q[i];
            data_d[i]      = data_q[i];
`ifdef PHY_RX_ERRCNT_EN
            err_d[i]       = err_q[i];
`endif
            if (!rx.enable) begin
                shift_d[i]     = 7'd0;
                state_d[i]     = SEARCH;
                comma_cnt_d[i] = 4'd0;
                valid_d[i]     = 1'b0;
`ifdef PHY_RX_ERRCNT_EN
                err_d[i]       = 8'd0;
`endif
            end else begin
                shift_d[i] = {shift_q[i][5:0], rx.in[i]};
                if (boundary) begin
                    valid_d[i] = 1'b0;
                    if (state_q[i] == SEARCH) begin
                        if (byte_w[i] == COMMA) begin
                            if (comma_cnt_q[i] < LOCK_CNT)
                                comma_cnt_d[i] = comma_cnt_q[i] + 4'd1;
                            // The locking comma itself never shows up as data.
                            if (comma_cnt_q[i] >= LOCK_CNT - 4'd1)
                                state_d[i] = ACTIVE;
                        end else begin
                            comma_cnt_d[i] = 4'd0;
`ifdef PHY_RX_ERRCNT_EN
                            if (err_q[i] != 8'hFF)
                                err_d[i] = err_q[i] + 8'd1;
`endif
                        end
                    end else if (byte_w[i] != COMMA) begin
                        data_d[i]  = byte_w[i];
                        valid_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt_q <= 3'd0;
            valid_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                shift_q[i]     <= 7'd0;
                state_q[i]     <= SEARCH;
                comma_cnt_q[i] <= 4'd0;
                data_q[i]      <= 8'd0;
`ifdef PHY_RX_ERRCNT_EN
                err_q[i]       <= 8'd0;
`endif
            end
        end else begin
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            for (int i = 0; i < LANES; i++) begin
                shift_q[i]     <= shift_d[i];
                state_q[i]     <= state_d[i];
                comma_cnt_q[i] <= comma_cnt_d[i];
                data_q[i]      <= data_d[i];
`ifdef PHY_RX_ERRCNT_EN
                err_q[i]       <= err_d[i];
`endif
            end
        end
    end

    assign rx.valid_out = valid_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign rx.data_out[8*g +: 8] = data_q[g];
        assign rx.active[g]          = (state_q[g] == ACTIVE);
`ifdef PHY_RX_ERRCNT_EN
        assign rx.err_cnt[8*g +: 8]  = err_q[g];
`endif
    end

endmodule

// File: tb/tb_phy_rx_sp_nlane.sv
// Directed table-driven bench for phy_rx_sp_nlane with two lanes.
// err_cnt checks are compiled in when PHY_RX_ERRCNT_EN is defined.
module tb_phy_rx_sp_nlane;
    logic clk_8f  = 1'b0;
    logic reset_L = 1'b0;

    phy_rx_sp_nlane_if #(.LANES(2)) bus ();

    phy_rx_sp_nlane #(.LANES(2), .COMMA(8'hBC), .COMMA_COUNT(4)) dut (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .rx      (bus)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        logic        pre_dis;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [1:0]  ev;
        logic [1:0]  ea;
        logic [15:0] ed;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  prev_v   = 2'b00;
    logic [1:0]  prev_a   = 2'b00;
    logic [15:0] prev_d   = 16'h0000;
    vec_t        tbl [18];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1);
        for (int k = 7; k >= 0; k--) begin
            bus.in = {b1[k], b0[k]};
            @(posedge clk_8f); #1;
            if (k == 4) begin
                check("hold_valid",  {14'd0, bus.valid_out}, {14'd0, prev_v});
                check("hold_active", {14'd0, bus.active},    {14'd0, prev_a});
                check("hold_data",   bus.data_out,           prev_d);
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        if (v.pre_dis) begin
            bus.enable = 1'b0;
            @(posedge clk_8f); #1;
            check({tag, "_dis_valid"},  {14'd0, bus.valid_out}, 16'd0);
            check({tag, "_dis_active"}, {14'd0, bus.active},    16'd0);
            check({tag, "_dis_data"},   bus.data_out,           prev_d);
            prev_v = 2'b00;
            prev_a = 2'b00;
            bus.enable = 1'b1;
        end
        send_byte(v.b0, v.b1);
        check({tag, "_valid"},  {14'd0, bus.valid_out}, {14'd0, v.ev});
        check({tag, "_active"}, {14'd0, bus.active},    {14'd0, v.ea});
        check({tag, "_data"},   bus.data_out,           v.ed);
        prev_v = v.ev;
        prev_a = v.ea;
        prev_d = v.ed;
    endtask

    initial begin
        //           dis   lane0   lane1   valid  active data {l1,l0}
        tbl[0]  = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'h0000};
        tbl[1]  = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'h0000};
        tbl[2]  = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'h0000};
        tbl[3]  = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b11, 16'h0000};
        tbl[4]  = '{1'b0, 8'hFF, 8'h00, 2'b11, 2'b11, 16'h00FF};
        tbl[5]  = '{1'b0, 8'hEE, 8'hEE, 2'b11, 2'b11, 16'hEEEE};
        tbl[6]  = '{1'b0, 8'hDD, 8'hDD, 2'b11, 2'b11, 16'hDDDD};
        tbl[7]  = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b11, 16'hDDDD};
        tbl[8]  = '{1'b0, 8'hAA, 8'hAA, 2'b11, 2'b11, 16'hAAAA};
        tbl[9]  = '{1'b1, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'hAAAA};
        tbl[10] = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'hAAAA};
        tbl[11] = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'hAAAA};
        tbl[12] = '{1'b0, 8'hBC, 8'h11, 2'b00, 2'b01, 16'hAAAA};
        tbl[13] = '{1'b0, 8'h55, 8'hBC, 2'b01, 2'b01, 16'hAA55};
        tbl[14] = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b01, 16'hAA55};
        tbl[15] = '{1'b0, 8'h66, 8'hBC, 2'b01, 2'b01, 16'hAA66};
        tbl[16] = '{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b11, 16'hAA66};
        tbl[17] = '{1'b0, 8'h12, 8'h34, 2'b11, 2'b11, 16'h3412};

        bus.enable = 1'b0;
        bus.in     = 2'b00;
        #12;
        check("rst_valid",  {14'd0, bus.valid_out}, 16'd0);
        check("rst_active", {14'd0, bus.active},    16'd0);
        check("rst_data",   bus.data_out,           16'd0);
`ifdef PHY_RX_ERRCNT_EN
        check("rst_err", bus.err_cnt, 16'd0);
`endif
        @(posedge clk_8f); #1;
        reset_L = 1'b1;
        @(posedge clk_8f); #1;
        bus.enable = 1'b1;

        for (int r = 0; r < 18; r++)
            apply_vec(tbl[r], $sformatf("vec%0d", r));

        // Asynchronous reset three bits into a byte while both lanes are locked.
        for (int k = 0; k < 3; k++) begin
            bus.in = 2'b11;
            @(posedge clk_8f); #1;
        end
        #2 reset_L = 1'b0;
        #1;
        check("arst_valid",  {14'd0, bus.valid_out}, 16'd0);
        check("arst_active", {14'd0, bus.active},    16'd0);
        check("arst_data",   bus.data_out,           16'd0);
        prev_v = 2'b00;
        prev_a = 2'b00;
        prev_d = 16'h0000;
        @(posedge clk_8f); #1;
        reset_L = 1'b1;
        apply_vec('{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'h0000}, "relock0");
        apply_vec('{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'h0000}, "relock1");
        apply_vec('{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b00, 16'h0000}, "relock2");
        apply_vec('{1'b0, 8'hBC, 8'hBC, 2'b00, 2'b11, 16'h0000}, "relock3");
        apply_vec('{1'b0, 8'h77, 8'h88, 2'b11, 2'b11, 16'h8877}, "relock_data");

`ifdef PHY_RX_ERRCNT_EN
        apply_vec('{1'b1, 8'h01, 8'h01, 2'b00, 2'b00, 16'h8877}, "err0");
        apply_vec('{1'b0, 8'h02, 8'hBC, 2'b00, 2'b00, 16'h8877}, "err1");
        apply_vec('{1'b0, 8'h03, 8'hBC, 2'b00, 2'b00, 16'h8877}, "err2");
        check("err_cnt_3", bus.err_cnt, 16'h0103);
        bus.enable = 1'b0;
        @(posedge clk_8f); #1;
        check("err_cnt_clr", bus.err_cnt, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
